cdb_arbiter: RTL and testbench

//   Serialises ALU and LSB results onto one shared common data bus (CDB).
//   - Each source gets its own result FIFO.
//   - A round-robin scheduler broadcasts at most one result per cycle.
//   - Consumers are the RS, LSB and ROB; they snoop the registered bus.
//   - Sits between the execution units and the CDB fan-out.

---
 rtl/cdb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Serialises ALU and LSB results onto one shared common data bus. Each
//   source owns a small result FIFO; a round-robin scheduler pops at most one
//   head per cycle and loads it into the registered broadcast outputs.
//
//   Parameters: DEPTH (entries per FIFO, power of 2, >=2), ROB_W, DATA_W.
//
//   Ports:
//     clk_in, rst_in          clock, asynchronous active-high reset
//     _flush                  synchronous clear of both FIFOs and the bus valid
//     _alu_cdb_*              ALU result input (ready/rob_id/value)
//     _alu_full               ALU FIFO full, ALU must hold its result
//     _lsb_cdb_*              LSB result input (ready/rob_id/value)
//     _lsb_full               LSB FIFO full, LSB must hold its result
//     _cdb_ready/_rob_id/_value/_src   registered broadcast (src 0=ALU, 1=LSB)
//     _overflow               sticky, a push arrived while its FIFO was full
//     _stat_bcast, _stat_conflict     only with CDB_ARB_STATS_EN defined
//
//   Optional feature macro: CDB_ARB_STATS_EN (broadcast / conflict counters).
module cdb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              _flush,
  input  logic              _alu_cdb_ready,
  input  logic [ROB_W-1:0]  _alu_cdb_rob_id,
  input  logic [DATA_W-1:0] _alu_cdb_value,
  output logic              _alu_full,
  input  logic              _lsb_cdb_ready,
  input  logic [ROB_W-1:0]  _lsb_cdb_rob_id,
  input  logic [DATA_W-1:0] _lsb_cdb_value,
  output logic              _lsb_full,
  output logic              _cdb_ready,
  output logic [ROB_W-1:0]  _cdb_rob_id,
  output logic [DATA_W-1:0] _cdb_value,
  output logic              _cdb_src,
`ifdef CDB_ARB_STATS_EN
  output logic [31:0]       _stat_bcast,
  output logic [31:0]       _stat_conflict,
`endif
  output logic              _overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // index 0 = ALU, index 1 = LSB throughout
  logic [ROB_W-1:0]  id_mem  [2][DEPTH];
  logic [DATA_W-1:0] val_mem [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr  [2];
  logic [PTR_W-1:0]  rd_ptr  [2];
  logic [CNT_W-1:0]  cnt     [2];
  logic              last_grant;

  logic [1:0]        in_v;
  logic [ROB_W-1:0]  in_id  [2];
  logic [DATA_W-1:0] in_val [2];
  logic [1:0]        full;
  logic [1:0]        has;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic              any_grant;
  logic              sel;
  logic [ROB_W-1:0]  head_id;
  logic [DATA_W-1:0] head_val;

  always_comb begin
    in_v      = {_lsb_cdb_ready, _alu_cdb_ready};
    in_id[0]  = _alu_cdb_rob_id;
    in_id[1]  = _lsb_cdb_rob_id;
    in_val[0] = _alu_cdb_value;
    in_val[1] = _lsb_cdb_value;
    for (int s = 0; s < 2; s++) begin
      full[s] = (cnt[s] == CNT_W'(DEPTH));
      has[s]  = (cnt[s] != '0);
    end
    // full is the registered view, so a full FIFO refuses a push even when
    // it is popped in the same cycle
    push      = in_v & ~full & {2{~_flush}};
    any_grant = |has;
    sel       = (has[0] & has[1]) ? ~last_grant : has[1];
    pop[0]    = any_grant & ~_flush & ~sel;
    pop[1]    = any_grant & ~_flush & sel;
    head_id   = sel ? id_mem[1][rd_ptr[1]]  : id_mem[0][rd_ptr[0]];
    head_val  = sel ? val_mem[1][rd_ptr[1]] : val_mem[0][rd_ptr[0]];
  end

  assign _alu_full = full[0];
  assign _lsb_full = full[1];

  // storage needs no reset: pointers and counts define what is valid
  always_ff @(posedge clk_in) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        id_mem[s][wr_ptr[s]]  <= in_id[s];
        val_mem[s][wr_ptr[s]] <= in_val[s];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      last_grant  <= 1'b1;
      _cdb_ready  <= 1'b0;
      _cdb_rob_id <= '0;
      _cdb_value  <= '0;
      _cdb_src    <= 1'b0;
      _overflow   <= 1'b0;
    end else if (_flush) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      _cdb_ready <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        case ({push[s], pop[s]})
          2'b10:   cnt[s] <= cnt[s] + CNT_W'(1);
          2'b01:   cnt[s] <= cnt[s] - CNT_W'(1);
          default: cnt[s] <= cnt[s];
        endcase
        if (in_v[s] && full[s]) _overflow <= 1'b1;
      end
      _cdb_ready <= any_grant;
      if (any_grant) begin
        _cdb_rob_id <= head_id;
        _cdb_value  <= head_val;
        _cdb_src    <= sel;
      end
      // last_grant only moves when there was a real tie to break, so a lone
      // source does not steal the next tie from the other one
      if (has[0] && has[1]) last_grant <= sel;
    end
  end

`ifdef CDB_ARB_STATS_EN
  // not cleared by _flush; wraps naturally at 2^32
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      _stat_bcast    <= '0;
      _stat_conflict <= '0;
    end else begin
      if (any_grant && !_flush) _stat_bcast <= _stat_bcast + 32'd1;
      if (has[0] && has[1])     _stat_conflict <= _stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int DEPTH  = 4;
  localparam int ROB_W  = 5;
  localparam int DATA_W = 32;
  localparam int EW     = ROB_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              av = 1'b0, lv = 1'b0;
  logic [ROB_W-1:0]  aid = '0, lid = '0;
  logic [DATA_W-1:0] aval = '0, lval = '0;
  logic              alu_full, lsb_full, cdb_ready, cdb_src, overflow;
  logic [ROB_W-1:0]  cdb_rob_id;
  logic [DATA_W-1:0] cdb_value;
`ifdef CDB_ARB_STATS_EN
  logic [31:0]       stat_bcast, stat_conflict;
`endif

  cdb_arbiter #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk_in(clk), .rst_in(rst), ._flush(flush),
    ._alu_cdb_ready(av), ._alu_cdb_rob_id(aid), ._alu_cdb_value(aval),
    ._alu_full(alu_full),
    ._lsb_cdb_ready(lv), ._lsb_cdb_rob_id(lid), ._lsb_cdb_value(lval),
    ._lsb_full(lsb_full),
    ._cdb_ready(cdb_ready), ._cdb_rob_id(cdb_rob_id), ._cdb_value(cdb_value),
    ._cdb_src(cdb_src),
`ifdef CDB_ARB_STATS_EN
    ._stat_bcast(stat_bcast), ._stat_conflict(stat_conflict),
`endif
    ._overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: one queue per source, holding {id, value}
  logic [EW-1:0]     qa[$];
  logic [EW-1:0]     ql[$];
  logic              m_last, m_ready, m_src, m_ovf;
  logic [ROB_W-1:0]  m_id;
  logic [DATA_W-1:0] m_val;
  logic [31:0]       m_bcast, m_conf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete(); ql.delete();
    m_last = 1'b1; m_ready = 1'b0; m_src = 1'b0; m_ovf = 1'b0;
    m_id = '0; m_val = '0; m_bcast = '0; m_conf = '0;
  endtask

  // one rising edge worth of the arbiter's rules, from pre-edge queue state
  task automatic model_edge();
    bit ha, hl, g, fa, fl;
    logic [EW-1:0] e;
    ha = (qa.size() > 0);
    hl = (ql.size() > 0);
    fa = (qa.size() == DEPTH);
    fl = (ql.size() == DEPTH);
    if (ha && hl) m_conf++;
    if (flush) begin
      qa.delete(); ql.delete();
      m_ready = 1'b0;
    end else begin
      if (ha || hl) begin
        g = (ha && hl) ? !m_last : hl;
        if (ha && hl) m_last = g;
        e = g ? ql.pop_front() : qa.pop_front();
        m_ready = 1'b1; m_src = g;
        m_id = e[EW-1:DATA_W]; m_val = e[DATA_W-1:0];
        m_bcast++;
      end else begin
        m_ready = 1'b0;
      end
      if (av) begin
        if (fa) m_ovf = 1'b1; else qa.push_back({aid, aval});
      end
      if (lv) begin
        if (fl) m_ovf = 1'b1; else ql.push_back({lid, lval});
      end
    end
  endtask

  task automatic check_model();
    chk("cdb_ready", 64'(cdb_ready), 64'(m_ready));
    chk("cdb_src", 64'(cdb_src), 64'(m_src));
    chk("cdb_rob_id", 64'(cdb_rob_id), 64'(m_id));
    chk("cdb_value", 64'(cdb_value), 64'(m_val));
    chk("alu_full", 64'(alu_full), 64'(qa.size() == DEPTH));
    chk("lsb_full", 64'(lsb_full), 64'(ql.size() == DEPTH));
    chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef CDB_ARB_STATS_EN
    chk("stat_bcast", 64'(stat_bcast), 64'(m_bcast));
    chk("stat_conflict", 64'(stat_conflict), 64'(m_conf));
`endif
  endtask

  // inputs are applied after the previous edge and sampled 1 time unit after this one
  task automatic step(input logic a_v, input logic [ROB_W-1:0] a_id, input logic [DATA_W-1:0] a_val,
                      input logic l_v, input logic [ROB_W-1:0] l_id, input logic [DATA_W-1:0] l_val,
                      input logic fl);
    av = a_v; aid = a_id; aval = a_val;
    lv = l_v; lid = l_id; lval = l_val;
    flush = fl;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    av = 1'b0; lv = 1'b0; flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    check_model();
  endtask

  typedef struct {
    logic              a_v;
    logic [ROB_W-1:0]  a_id;
    logic [DATA_W-1:0] a_val;
    logic              l_v;
    logic [ROB_W-1:0]  l_id;
    logic [DATA_W-1:0] l_val;
    logic              fl;
    logic              e_rdy;
    logic [ROB_W-1:0]  e_id;
    logic [DATA_W-1:0] e_val;
    logic              e_src;
  } vec_t;

  function automatic vec_t mk(logic a_v, int a_id, int a_val, logic l_v, int l_id, int l_val,
                              logic fl, logic e_rdy, int e_id, int e_val, logic e_src);
    vec_t v;
    v.a_v = a_v; v.a_id = ROB_W'(a_id); v.a_val = DATA_W'(a_val);
    v.l_v = l_v; v.l_id = ROB_W'(l_id); v.l_val = DATA_W'(l_val);
    v.fl = fl; v.e_rdy = e_rdy; v.e_id = ROB_W'(e_id); v.e_val = DATA_W'(e_val);
    v.e_src = e_src;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    bit reached;

    // single push, tie, LSB burst, flush with a pending entry
    tbl[0]  = mk(1, 3, 'h11, 0, 0, 0,    0, 0, 0, 0,    0);
    tbl[1]  = mk(0, 0, 0,    0, 0, 0,    0, 1, 3, 'h11, 0);
    tbl[2]  = mk(0, 0, 0,    0, 0, 0,    0, 0, 3, 'h11, 0);
    tbl[3]  = mk(1, 1, 'hA,  1, 2, 'hB,  0, 0, 3, 'h11, 0);
    tbl[4]  = mk(0, 0, 0,    0, 0, 0,    0, 1, 1, 'hA,  0);
    tbl[5]  = mk(0, 0, 0,    0, 0, 0,    0, 1, 2, 'hB,  1);
    tbl[6]  = mk(0, 0, 0,    1, 5, 'h55, 0, 0, 2, 'hB,  1);
    tbl[7]  = mk(0, 0, 0,    1, 6, 'h66, 0, 1, 5, 'h55, 1);
    tbl[8]  = mk(0, 0, 0,    1, 7, 'h77, 0, 1, 6, 'h66, 1);
    tbl[9]  = mk(0, 0, 0,    0, 0, 0,    0, 1, 7, 'h77, 1);
    tbl[10] = mk(0, 0, 0,    0, 0, 0,    0, 0, 7, 'h77, 1);
    tbl[11] = mk(1, 8, 'h80, 0, 0, 0,    0, 0, 7, 'h77, 1);
    tbl[12] = mk(1, 9, 'h90, 0, 0, 0,    1, 0, 7, 'h77, 1);
    tbl[13] = mk(0, 0, 0,    0, 0, 0,    0, 0, 7, 'h77, 1);
    tbl[14] = mk(0, 0, 0,    0, 0, 0,    0, 0, 7, 'h77, 1);

    rst = 1'b1;
    #2;
    chk("reset_ready", 64'(cdb_ready), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].a_v, tbl[i].a_id, tbl[i].a_val, tbl[i].l_v, tbl[i].l_id, tbl[i].l_val, tbl[i].fl);
      chk($sformatf("tbl%0d_ready", i), 64'(cdb_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_id", i), 64'(cdb_rob_id), 64'(tbl[i].e_id));
      chk($sformatf("tbl%0d_value", i), 64'(cdb_value), 64'(tbl[i].e_val));
      chk($sformatf("tbl%0d_src", i), 64'(cdb_src), 64'(tbl[i].e_src));
      chk($sformatf("tbl%0d_alu_full", i), 64'(alu_full), 64'd0);
      chk($sformatf("tbl%0d_overflow", i), 64'(overflow), 64'd0);
    end

    // both sources push every cycle: alternation, full, then overflow
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'b1, ROB_W'(i), DATA_W'(32'h100 + i), 1'b1, ROB_W'(16 + i), DATA_W'(32'h200 + i), 1'b0);
    chk("burst_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 12; i++) idle();
    chk("burst_drained", 64'(cdb_ready), 64'd0);
    chk("burst_overflow_sticky", 64'(overflow), 64'd1);

    // flush with three ALU entries queued and a push in the same cycle
    do_reset();
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step(1'b1, ROB_W'(i), DATA_W'(32'h300 + i), 1'b1, ROB_W'(i + 8), DATA_W'(32'h400 + i), 1'b0);
      if (qa.size() == 3) reached = 1;
    end
    chk("flush_fill_reached", 64'(reached), 64'd1);
    step(1'b1, 5'd31, 32'hDEAD, 1'b0, '0, '0, 1'b1);
    chk("flush_ready", 64'(cdb_ready), 64'd0);
    chk("flush_alu_full", 64'(alu_full), 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("flush_no_stale", 64'(cdb_ready), 64'd0);
    end

    // asynchronous reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 5; i++)
      step(1'b1, ROB_W'(i), DATA_W'(i), 1'b1, ROB_W'(i + 20), DATA_W'(i + 20), 1'b0);
    av = 1'b0; lv = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("areset_ready", 64'(cdb_ready), 64'd0);
    chk("areset_id", 64'(cdb_rob_id), 64'd0);
    chk("areset_value", 64'(cdb_value), 64'd0);
    chk("areset_src", 64'(cdb_src), 64'd0);
    chk("areset_overflow", 64'(overflow), 64'd0);
    chk("areset_alu_full", 64'(alu_full), 64'd0);
    chk("areset_lsb_full", 64'(lsb_full), 64'd0);
`ifdef CDB_ARB_STATS_EN
    chk("areset_bcast", 64'(stat_bcast), 64'd0);
    chk("areset_conflict", 64'(stat_conflict), 64'd0);
`endif
    model_reset();
    #1;
    rst = 1'b0;
    step(1'b1, 5'd4, 32'h44, 1'b0, '0, '0, 1'b0);
    chk("post_reset_wait", 64'(cdb_ready), 64'd0);
    idle();
    chk("post_reset_ready", 64'(cdb_ready), 64'd1);
    chk("post_reset_id", 64'(cdb_rob_id), 64'd4);
    chk("post_reset_value", 64'(cdb_value), 64'h44);

    // randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 55, ROB_W'($urandom), DATA_W'($urandom),
           $urandom_range(0, 99) < 55, ROB_W'($urandom), DATA_W'($urandom),
           $urandom_range(0, 99) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
